// File: rtl/frame_buffer_pkg.sv
// frame_buffer_pkg: bank and FSM state encodings for the ping-pong frame buffer
package frame_buffer_pkg;
  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_READING} bank_st_t;
  typedef enum logic {WR_FILL, WR_DROP} wr_st_t;
  typedef enum logic [1:0] {RD_IDLE, RD_STREAM, RD_DRAIN} rd_st_t;
endpackage

// File: rtl/libdigital_pkg.sv
// libdigital_pkg: shared helpers (ceiling log2, bit-reversal) used across the digital blocks
package libdigital_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (i < w) r[i] = v[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/frame_ram.sv
// frame_ram: simple dual-port RAM, one write port, one synchronous read port (read data holds when re is low)
module frame_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 14
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  input  logic                         re,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  output logic signed [DATA_WIDTH-1:0] rdata
);
  logic signed [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/frame_buffer.sv
// frame_buffer: ping-pong buffer turning a windowed sample stream into N-sample frames with valid/ready output
// Ports: clk, rst_n (async, active-low); di_valid/di in; dout_valid/dout_ready/dout/dout_sof/dout_eof out;
// overflow pulses for one cycle when a whole frame is dropped because no bank was free at its first sample.
// N must be a power of two, at least 4.
module frame_buffer
  import libdigital_pkg::*;
  import frame_buffer_pkg::*;
#(
  parameter int N          = 1024,
  parameter int DATA_WIDTH = 14,
  parameter int BIT_REV    = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         di_valid,
  input  logic signed [DATA_WIDTH-1:0] di,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         dout_sof,
  output logic                         dout_eof,
  output logic                         overflow
);
  localparam int LN = clog2(N);
  bank_st_t bank [2];
  bank_st_t bank_nxt [2];
  wr_st_t wst, wst_nxt;
  rd_st_t rd_st, rd_nxt;
  logic [LN-1:0] wcnt, ridx, ridx_nxt;
  logic wbank, wbank_nxt, rbank, rbank_nxt, wsel, wb;
  logic xfer, rel, free0, free1, start, claim, we, last_w, rd_claim;
  logic s1_v, s1_sof, s1_eof, s1_move, issue;
  logic [LN:0] waddr, raddr;
  logic signed [DATA_WIDTH-1:0] rdata;
  assign xfer    = dout_valid & dout_ready;
  assign rel     = xfer & dout_eof;
  // a bank released by the eof transfer is claimable by a count-0 sample in the same cycle
  assign free0   = bank[0] == BANK_EMPTY || (rel && !rbank);
  assign free1   = bank[1] == BANK_EMPTY || (rel && rbank);
  assign start   = di_valid && wcnt == '0;
  assign claim   = start && (free0 || free1);
  assign wsel    = !free0;
  assign wb      = start ? wsel : wbank;
  assign we      = di_valid && (start ? claim : wst == WR_FILL);
  assign last_w  = di_valid && wcnt == LN'(N - 1) && wst == WR_FILL;
  assign waddr   = {wb, wcnt};
  // stage 1 is the RAM output register; it advances only when the output register can take it
  assign s1_move = s1_v && (!dout_valid || dout_ready);
  assign issue   = rd_st == RD_STREAM && (!s1_v || s1_move);
  assign raddr   = {rbank, BIT_REV != 0 ? LN'(bit_rev(32'(ridx), LN)) : ridx};
  assign wst_nxt   = start ? (claim ? WR_FILL : WR_DROP) : wst;
  assign wbank_nxt = claim ? wsel : wbank;
  always_comb begin
    rd_nxt   = rd_st;
    rbank_nxt = rbank;
    ridx_nxt = ridx;
    rd_claim = 1'b0;
    case (rd_st)
      RD_IDLE: if (bank[0] == BANK_FULL || bank[1] == BANK_FULL) begin
        rd_nxt    = RD_STREAM;
        rbank_nxt = bank[0] != BANK_FULL;
        ridx_nxt  = '0;
        rd_claim  = 1'b1;
      end
      RD_STREAM: if (issue) begin
        ridx_nxt = ridx + 1'b1;
        rd_nxt   = ridx == LN'(N - 1) ? RD_DRAIN : RD_STREAM;
      end
      RD_DRAIN: rd_nxt = rel ? RD_IDLE : RD_DRAIN;
      default: rd_nxt = RD_IDLE;
    endcase
  end
  always_comb begin
    bank_nxt = bank;
    if (rel) bank_nxt[rbank] = BANK_EMPTY;
    if (rd_claim) bank_nxt[rbank_nxt] = BANK_READING;
    if (claim) bank_nxt[wsel] = BANK_FILLING;
    if (last_w) bank_nxt[wbank] = BANK_FULL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank[0]    <= BANK_EMPTY;
      bank[1]    <= BANK_EMPTY;
      wst        <= WR_DROP;
      wcnt       <= '0;
      wbank      <= 1'b0;
      rd_st      <= RD_IDLE;
      rbank      <= 1'b0;
      ridx       <= '0;
      s1_v       <= 1'b0;
      s1_sof     <= 1'b0;
      s1_eof     <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      bank     <= bank_nxt;
      wst      <= wst_nxt;
      wcnt     <= di_valid ? wcnt + 1'b1 : wcnt;
      wbank    <= wbank_nxt;
      rd_st    <= rd_nxt;
      rbank    <= rbank_nxt;
      ridx     <= ridx_nxt;
      overflow <= start && !claim;
      if (issue) begin
        s1_v   <= 1'b1;
        s1_sof <= ridx == '0;
        s1_eof <= ridx == LN'(N - 1);
      end else if (s1_move) s1_v <= 1'b0;
      if (!dout_valid || dout_ready) begin
        dout_valid <= s1_v;
        dout_sof   <= s1_v && s1_sof;
        dout_eof   <= s1_v && s1_eof;
        dout       <= s1_v ? rdata : dout;
      end
    end
  end
  frame_ram #(.ADDR_WIDTH(LN + 1), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(di),
    .re(issue),
    .raddr(raddr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: scoreboard bench driving a natural-order and a bit-reversed instance with the same stream
module tb_frame_buffer;
  localparam int N = 8;
  localparam int DW = 14;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic di_valid = 1'b0;
  logic dout_ready = 1'b0;
  logic signed [DW-1:0] di = '0;
  logic v0, s0, e0, o0, v1, s1, e1, o1;
  logic signed [DW-1:0] d0, d1;
  typedef struct packed {
    logic signed [DW-1:0] d;
    logic s;
    logic e;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad = 0;
  int ovf0 = 0;
  int ovf1 = 0;
  int b0, b1;
  bit rnd = 0;
  int fr[N];
  logic p_stall[2];
  int p_d[2];
  logic p_s[2];
  logic p_e[2];
  always #5 clk = ~clk;
  frame_buffer #(.N(N), .DATA_WIDTH(DW), .BIT_REV(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .di_valid(di_valid), .di(di), .dout_valid(v0),
    .dout_ready(dout_ready), .dout(d0), .dout_sof(s0), .dout_eof(e0), .overflow(o0)
  );
  frame_buffer #(.N(N), .DATA_WIDTH(DW), .BIT_REV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .di_valid(di_valid), .di(di), .dout_valid(v1),
    .dout_ready(dout_ready), .dout(d1), .dout_sof(s1), .dout_eof(e1), .overflow(o1)
  );
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int br(input int j);
    logic [2:0] b;
    b = 3'(j);
    return int'({b[0], b[1], b[2]});
  endfunction
  task automatic mon(input int id, input logic v, input logic r, input logic signed [DW-1:0] d,
                     input logic s, input logic e);
    exp_t x;
    if (p_stall[id]) begin
      chk($sformatf("hold_valid%0d", id), int'(v), 1);
      chk($sformatf("hold_dout%0d", id), int'(d), p_d[id]);
      chk($sformatf("hold_sof%0d", id), int'(s), int'(p_s[id]));
      chk($sformatf("hold_eof%0d", id), int'(e), int'(p_e[id]));
    end
    if (v && r) begin
      if ((id == 0 ? q0.size() : q1.size()) == 0) chk($sformatf("spurious%0d", id), int'(v), 0);
      else begin
        if (id == 0) x = q0.pop_front();
        else x = q1.pop_front();
        chk($sformatf("dout%0d", id), int'(d), int'(x.d));
        chk($sformatf("sof%0d", id), int'(s), int'(x.s));
        chk($sformatf("eof%0d", id), int'(e), int'(x.e));
      end
    end
    p_stall[id] = v && !r;
    p_d[id] = int'(d);
    p_s[id] = s;
    p_e[id] = e;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall[0] = 1'b0;
      p_stall[1] = 1'b0;
    end else begin
      mon(0, v0, dout_ready, d0, s0, e0);
      mon(1, v1, dout_ready, d1, s1, e1);
      ovf0 += int'(o0);
      ovf1 += int'(o1);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) dout_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic send_frame(input bit store);
    if (store)
      for (int i = 0; i < N; i++) begin
        q0.push_back('{d: DW'(fr[i]), s: (i == 0), e: (i == N - 1)});
        q1.push_back('{d: DW'(fr[br(i)]), s: (i == 0), e: (i == N - 1)});
      end
    for (int i = 0; i < N; i++) begin
      di = DW'(fr[i]);
      di_valid = 1'b1;
      tick();
    end
    di_valid = 1'b0;
    di = '0;
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) tick();
    chk({tag, "_left0"}, q0.size(), 0);
    chk({tag, "_left1"}, q1.size(), 0);
    repeat (15) tick();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid0"}, int'(v0), 0);
    chk({tag, "_dout0"}, int'(d0), 0);
    chk({tag, "_sof0"}, int'(s0), 0);
    chk({tag, "_eof0"}, int'(e0), 0);
    chk({tag, "_ovf0"}, int'(o0), 0);
    chk({tag, "_valid1"}, int'(v1), 0);
    chk({tag, "_dout1"}, int'(d1), 0);
    chk({tag, "_sof1"}, int'(s1), 0);
    chk({tag, "_eof1"}, int'(e1), 0);
    chk({tag, "_ovf1"}, int'(o1), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    dout_ready = 1'b1;
    tick();
    for (int i = 0; i < N; i++) fr[i] = i;
    b0 = ovf0;
    b1 = ovf1;
    send_frame(1);
    drain("ramp");
    chk("ramp_ovf0", ovf0 - b0, 0);
    chk("ramp_ovf1", ovf1 - b1, 0);
    fr = '{-8192, 8191, -1, 1, 0, -4096, 4095, -2};
    send_frame(1);
    drain("extreme");
    dout_ready = 1'b0;
    b0 = ovf0;
    b1 = ovf1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) fr[i] = 100 + 10 * f + i;
      send_frame(f < 2);
    end
    tick();
    chk("drop_ovf0", ovf0 - b0, 2);
    chk("drop_ovf1", ovf1 - b1, 2);
    dout_ready = 1'b1;
    repeat (20) tick();
    for (int i = 0; i < N; i++) fr[i] = 200 + i;
    send_frame(1);
    drain("drop");
    rnd = 1;
    for (int i = 0; i < N; i++) fr[i] = i;
    send_frame(1);
    for (int i = 0; i < N; i++) fr[i] = i + 8;
    send_frame(1);
    drain("rand");
    rnd = 0;
    dout_ready = 1'b0;
    for (int i = 0; i < N; i++) fr[i] = 50 + i;
    send_frame(0);
    repeat (5) tick();
    chk("pending_valid0", int'(v0), 1);
    chk("pending_dout0", int'(d0), 50);
    for (int i = 0; i < 3; i++) begin
      di = DW'(60 + i);
      di_valid = 1'b1;
      tick();
    end
    di_valid = 1'b0;
    q0.delete();
    q1.delete();
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dout_ready = 1'b1;
    tick();
    for (int i = 0; i < N; i++) fr[i] = 20 + i;
    send_frame(1);
    drain("postreset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_buffer.md
FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
REQ-001 The block SHALL have parameter N, default 1024, giving frame length in samples; N SHALL be a power of two and at least 4.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 14, giving the signed sample width, equal to the upstream window output width.
REQ-003 The block SHALL have parameter BIT_REV, default 0; when 1, each frame SHALL be read out in bit-reversed index order.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge clocked.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port di_valid, input, 1 bit: di holds a windowed sample this cycle.
REQ-007 Port di, input, DATA_WIDTH bits, signed: windowed sample.
REQ-008 Port dout_valid, output, 1 bit: dout holds a frame sample.
REQ-009 Port dout_ready, input, 1 bit: the consumer accepts dout this cycle.
REQ-010 Port dout, output, DATA_WIDTH bits, signed: frame sample.
REQ-011 Port dout_sof, output, 1 bit: dout is the first sample of a frame.
REQ-012 Port dout_eof, output, 1 bit: dout is the last sample of a frame.
REQ-013 Port overflow, output, 1 bit: one-cycle pulse when a frame is dropped.

Function
REQ-014 The block SHALL hold two banks of N samples (ping-pong); each bank is EMPTY, FILLING, FULL or READING.
REQ-015 The write counter SHALL count every di_valid sample modulo N, whether stored or dropped, so frame boundaries stay aligned to the upstream coefficient index.
REQ-016 At write count 0, the write FSM SHALL enter FILL and claim an EMPTY bank if one exists; otherwise it SHALL enter DROP and pulse overflow in that same cycle.
REQ-017 In FILL, sample k of the frame SHALL be written to address k of the claimed bank; at count N-1 that bank SHALL become FULL.
REQ-018 In DROP, samples SHALL be discarded until count N-1; no partial frame SHALL ever be emitted.
REQ-019 The read FSM SHALL be IDLE until a bank is FULL, then switch to STREAM on that bank; FULL banks SHALL be read oldest first.
REQ-020 In STREAM, read index j = 0..N-1 SHALL map to address j, or to bit-reverse(j) over log2(N) bits when BIT_REV=1.
REQ-021 A sample SHALL transfer on any cycle with dout_valid and dout_ready both high.
REQ-022 While dout_valid is high and dout_ready is low, dout, dout_sof and dout_eof SHALL hold stable.
REQ-023 Throughput SHALL be one sample per cycle while dout_ready is held high.
REQ-024 dout_sof SHALL be high only with index 0, and dout_eof only with index N-1.
REQ-025 After the eof transfer, the bank SHALL become EMPTY in that cycle, and the writer SHALL be able to claim it at a count-0 sample arriving in the same cycle.
REQ-026 The first dout_valid of a frame SHALL assert no later than 3 cycles after the frame's last write, provided the read FSM is IDLE.
REQ-027 Data SHALL pass unmodified: no rounding, scaling or sign change.
REQ-028 di SHALL be ignored whenever di_valid is low, and the write counter SHALL NOT advance in those cycles.

Reset
REQ-029 While rst_n is low, both FSMs SHALL go to their initial states (write FSM at count 0, read FSM IDLE), both banks SHALL be EMPTY, and dout_valid, dout_sof, dout_eof, overflow and dout SHALL be 0.
REQ-030 RAM contents SHALL NOT be reset, and no stale frame SHALL be emitted after reset.
REQ-031 After rst_n rises, the first di_valid sample SHALL be treated as frame index 0.

Structure
REQ-032 A single sub-module frame_ram SHALL implement the storage: simple dual-port, 2N x DATA_WIDTH, one-cycle synchronous read, with the bank select as the address MSB.
REQ-033 The clog2 helper and the bit-reverse function SHALL live in the shared libdigital include, not local to this block.

Verification
REQ-034 N=8, BIT_REV=0, ramp di=0..7 on consecutive cycles, ready=1 -> dout 0..7 with sof on 0, eof on 7, and no overflow.
REQ-035 N=8, BIT_REV=1, same stimulus -> dout order 0,4,2,6,1,5,3,7.
REQ-036 N=8, ready=0 while four frames arrive back-to-back, then ready=1 -> frames 1 and 2 are emitted in order; overflow pulses at the first sample of frames 3 and 4; frame 5 is stored.
REQ-037 Random dout_ready toggling -> the output sequence is identical to REQ-034 and all outputs hold stable while valid is high and ready is low.
REQ-038 rst_n pulsed low at write count 3 -> outputs are 0 immediately; the next 8 samples form the first emitted frame.
REQ-039 di of -8192 and 8191 (DATA_WIDTH=14) -> the same values appear bit-exact on dout.
